// File: rtl/shift_reg_piso_pkg.sv
// Shared types and defaults for the PIPO/PISO/SIPO register family.
// State encoding and the default word width live here.
package shift_reg_piso_pkg;

    localparam int PISO_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_reg_piso_if.sv
// Parallel-in handshake and serial-out bundle for shift_reg_piso.
// slave is the PISO side, master is the upstream/downstream side.
interface shift_reg_piso_if
    import shift_reg_piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
);

    logic [WIDTH-1:0] D;
    logic             in_valid;
    logic             in_ready;
    logic             out_en;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport slave (
        input  D, in_valid, out_en,
        output in_ready, ser_out, ser_valid,
        output frame_start, frame_end, busy
    );

    modport master (
        output D, in_valid, out_en,
        input  in_ready, ser_out, ser_valid,
        input  frame_start, frame_end, busy
    );

endinterface

// File: rtl/shift_reg_piso_bit_counter.sv
// Bit position counter, 0..WIDTH-1, saturating at the terminal count.
// Clear wins over enable so a new word always restarts at bit 0.
module bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (cnt == LAST);

    // count up while enabled, never past the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_reg_piso.sv
// Parallel-in/serial-out stage fed from the PIPO register.
// Accepts a word per handshake, streams it out one bit per enabled clock.
module shift_reg_piso
    import shift_reg_piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_piso_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             advance;
    logic             done;
    logic             ready;
    logic             accept;
    logic             shifting;

    assign shifting = (state == ST_SHIFT);
    assign advance  = shifting && bus.out_en;
    assign done     = advance && tc;
    assign ready    = (state == ST_IDLE) || done;
    assign accept   = bus.in_valid && ready;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .clr   (accept || done),
        .cnt   (cnt),
        .tc    (tc)
    );

    // bit-reverse on load so the shifter always drains from the top bit
    always_comb begin
        load_word = bus.D;
        if (LSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                load_word[i] = bus.D[WIDTH-1-i];
            end
        end
    end

    // shift register: load on accept, shift on each enabled non-final bit
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= load_word;
        end else if (advance && !tc) begin
            shreg <= shreg << 1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state: stay in SHIFT across back-to-back words
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (done) begin
                    state_nx = accept ? ST_SHIFT : ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.in_ready    = ready;
    assign bus.ser_valid   = shifting;
    assign bus.ser_out     = shifting && shreg[WIDTH-1];
    assign bus.frame_start = shifting && (cnt == '0);
    assign bus.frame_end   = shifting && tc;
    assign bus.busy        = shifting;

endmodule

// File: tb/tb_shift_reg_piso.sv
// Bench for shift_reg_piso: MSB-first and LSB-first instances side by side,
// table vectors, directed corner sequences and random traffic vs a queue model.
module tb_shift_reg_piso;

    localparam int W = 4;

    typedef struct {
        bit         r;
        bit         v;
        logic [3:0] d;
        bit         oe;
        bit         sv;
        bit         so;
        bit         fs;
        bit         fe;
        bit         rdy;
        bit         bz;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    shift_reg_piso_if #(.WIDTH(W)) bm ();
    shift_reg_piso_if #(.WIDTH(W)) bl ();

    shift_reg_piso #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bm.slave)
    );

    shift_reg_piso #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bl.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit last_acc = 1'b0;
    bit qm[$];
    bit ql[$];
    vec_t tbl[6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit v,
                                input logic [3:0] d, input bit oe);
        vec_t x;
        x = '{r, v, d, oe, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        return x;
    endfunction

    task automatic cmp_side(input string tag, input bit q[$], input bit rdy,
                            input logic sv, input logic so, input logic fs,
                            input logic fe, input logic ir, input logic bz);
        bit e_sv;
        e_sv = (q.size() != 0);
        chk({tag, ".ser_valid"}, sv, e_sv);
        chk({tag, ".ser_out"}, so, e_sv ? q[0] : 1'b0);
        chk({tag, ".frame_start"}, fs, q.size() == W);
        chk({tag, ".frame_end"}, fe, q.size() == 1);
        chk({tag, ".in_ready"}, ir, rdy);
        chk({tag, ".busy"}, bz, e_sv);
    endtask

    // one clock: drive, check mid-cycle, then advance the reference model
    task automatic step(input vec_t t, input bit use_exp);
        bit rdy;
        int n;
        reset       = t.r;
        bm.in_valid = t.v;
        bm.D        = t.d;
        bm.out_en   = t.oe;
        bl.in_valid = t.v;
        bl.D        = t.d;
        bl.out_en   = t.oe;
        #1;
        n   = qm.size();
        rdy = (n == 0) || (n == 1 && t.oe);
        if (chk_en) begin
            cmp_side("msb", qm, rdy, bm.ser_valid, bm.ser_out,
                     bm.frame_start, bm.frame_end, bm.in_ready, bm.busy);
            cmp_side("lsb", ql, rdy, bl.ser_valid, bl.ser_out,
                     bl.frame_start, bl.frame_end, bl.in_ready, bl.busy);
        end
        if (use_exp) begin
            chk("tbl.ser_valid", bm.ser_valid, t.sv);
            chk("tbl.ser_out", bm.ser_out, t.so);
            chk("tbl.frame_start", bm.frame_start, t.fs);
            chk("tbl.frame_end", bm.frame_end, t.fe);
            chk("tbl.in_ready", bm.in_ready, t.rdy);
            chk("tbl.busy", bm.busy, t.bz);
        end
        @(posedge clk);
        last_acc = 1'b0;
        if (t.r) begin
            qm.delete();
            ql.delete();
        end else begin
            last_acc = t.v && rdy;
            if (n != 0 && t.oe) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (last_acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(t.d[W-1-i]);
                    ql.push_back(t.d[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(mk(0, 0, 4'h0, 1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit         hold;
        bit         v;
        bit         r;
        bit         oe;
        logic [3:0] d;
        logic [7:0] pat;
        logic [3:0] ds [8];
        bit         vs [8];
        bit         stall_oe [6];
        bit         stall_so [6];

        tbl[0] = '{0, 1, 4'b1011, 1, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{0, 0, 4'b0000, 1, 1, 1, 1, 0, 0, 1};
        tbl[2] = '{0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 1};
        tbl[3] = '{0, 0, 4'b0000, 1, 1, 1, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 4'b0000, 1, 1, 1, 0, 1, 1, 1};
        tbl[5] = '{0, 0, 4'b0000, 1, 0, 0, 0, 0, 1, 0};

        // reset
        step(mk(1, 0, 4'h0, 1), 0);
        step(mk(1, 0, 4'h0, 1), 0);
        chk("rst.ser_valid", bm.ser_valid, 1'b0);
        chk("rst.busy", bm.busy, 1'b0);
        chk("rst.in_ready", bm.in_ready, 1'b1);
        chk("rst.ser_out", bm.ser_out, 1'b0);
        chk("rst.lsb_valid", bl.ser_valid, 1'b0);
        chk_en = 1'b1;

        // single word from table
        foreach (tbl[i]) step(tbl[i], 1);
        idle(2);

        // back-to-back A then 5
        pat = 8'b1010_0101;
        for (int k = 0; k < 8; k++) begin
            vs[k] = (k <= 4);
            ds[k] = (k == 0) ? 4'hA : 4'h5;
        end
        for (int k = 0; k < 8; k++) begin
            step(mk(0, vs[k], ds[k], 1), 0);
            chk("b2b.ser_valid", bm.ser_valid, 1'b1);
            chk("b2b.ser_out", bm.ser_out, pat[7-k]);
            chk("b2b.in_ready", bm.in_ready, (k == 3) || (k == 7));
        end
        step(mk(0, 0, 4'h0, 1), 0);
        chk("b2b.end_valid", bm.ser_valid, 1'b0);
        idle(1);

        // stall after bit 1
        stall_oe = '{1, 1, 0, 0, 1, 1};
        stall_so = '{1, 1, 1, 1, 0, 0};
        for (int k = 0; k < 6; k++) begin
            step(mk(0, k == 0, 4'b1100, stall_oe[k]), 0);
            chk("stall.ser_out", bm.ser_out, stall_so[k]);
            chk("stall.ser_valid", bm.ser_valid, 1'b1);
        end
        chk("stall.frame_end", bm.frame_end, 1'b1);
        step(mk(0, 0, 4'h0, 1), 0);
        chk("stall.end_valid", bm.ser_valid, 1'b0);
        idle(1);

        // reset mid-word
        step(mk(0, 1, 4'b0110, 1), 0);
        step(mk(0, 0, 4'h0, 1), 0);
        chk("midrst.bit1", bm.ser_out, 1'b1);
        step(mk(1, 0, 4'h0, 1), 0);
        chk("midrst.ser_valid", bm.ser_valid, 1'b0);
        chk("midrst.in_ready", bm.in_ready, 1'b1);
        chk("midrst.frame_end", bm.frame_end, 1'b0);
        idle(2);

        // LSB first, plus a word offered while not ready
        step(mk(0, 1, 4'b0001, 1), 0);
        chk("lsb.bit0", bl.ser_out, 1'b1);
        chk("lsb.fs", bl.frame_start, 1'b1);
        step(mk(0, 0, 4'h0, 1), 0);
        chk("lsb.bit1", bl.ser_out, 1'b0);
        step(mk(0, 0, 4'h0, 1), 0);
        chk("lsb.bit2", bl.ser_out, 1'b0);
        chk("lsb.in_ready", bl.in_ready, 1'b0);
        step(mk(0, 1, 4'hF, 1), 0);
        chk("lsb.bit3", bl.ser_out, 1'b0);
        chk("lsb.fe", bl.frame_end, 1'b1);
        step(mk(0, 0, 4'h0, 1), 0);
        chk("lsb.not_taken", bl.ser_valid, 1'b0);
        idle(1);

        // random traffic against the queue model
        hold = 1'b0;
        v    = 1'b0;
        d    = 4'h0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!hold) begin
                v = ($urandom_range(0, 2) != 0);
                d = 4'($urandom);
            end
            oe = ($urandom_range(0, 3) != 0);
            step(mk(r, v, d, oe), 0);
            hold = v && !last_acc && !r;
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
